alu_rr_arbiter: RTL and testbench

Shares one combinational 32-bit ALU (opcodes ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, all others produce 0) among NUM_REQ requesters. Requests are selected round-robin and presented to the ALU from registered operands. The ALU result is captured and returned on a single valid/ready response channel tagged with the requester id. The block sits between the requesting units and the shared ALU instance, and is the only driver of the ALU's inputs.

---
 rtl/alu_rr_arbiter.sv | 115 +++++++++++
 tb/tb_alu_rr_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one external combinational 32-bit ALU among NUM_REQ requesters.
// The winner's operands are registered, executed for one cycle, and returned on a tagged valid/ready channel.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_opcode,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [3:0]              alu_opcode,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  input  logic [31:0]             alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    rsp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     id_r;
  logic                any_valid;
  logic [ID_W-1:0]     win;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [3:0]          win_op;
  logic [31:0]         win_a;
  logic [31:0]         win_b;

  // Scan priority offsets 1..NUM_REQ after last_grant; inner loop keeps every select constant.
  always_comb begin
    any_valid  = 1'b0;
    win        = '0;
    win_onehot = '0;
    win_op     = '0;
    win_a      = '0;
    win_b      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any_valid && req_valid[i] && (((32'(last_grant) + k) % NUM_REQ) == i)) begin
          any_valid     = 1'b1;
          win           = ID_W'(i);
          win_onehot[i] = 1'b1;
          win_op        = req_opcode[4*i +: 4];
          win_a         = req_a[32*i +: 32];
          win_b         = req_b[32*i +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst) req_ready = win_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      id_r        <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_opcode <= win_op;
            alu_a      <= win_a;
            alu_b      <= win_b;
            id_r       <= win;
            last_grant <= win;
          end
        end
        EXEC: begin
          rsp_result  <= alu_result;
          rsp_id      <= id_r;
          rsp_illegal <= (alu_opcode > 4'b0100);
          rsp_valid   <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares on every accepted response.
module tb_alu_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_opcode;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [3:0]            alu_opcode;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [31:0]           alu_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_illegal;

  logic [3:0]  op_t [NUM_REQ];
  logic [31:0] a_t  [NUM_REQ];
  logic [31:0] b_t  [NUM_REQ];

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     res;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_opcode[4*i +: 4] = op_t[i];
      req_a[32*i +: 32]    = a_t[i];
      req_b[32*i +: 32]    = b_t[i];
    end
  end

  // The shared ALU the arbiter drives.
  always_comb begin
    case (alu_opcode)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_illegal (rsp_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got id %0d result %0h, expected no response", rsp_id, rsp_result);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id",      64'(rsp_id),      64'(mon_e.id));
        chk("rsp_result",  64'(rsp_result),  64'(mon_e.res));
        chk("rsp_illegal", 64'(rsp_illegal), 64'(mon_e.ill));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_t[r] = op;
    a_t[r]  = a;
    b_t[r]  = b;
  endtask

  task automatic push(input int id, input logic [31:0] res, input logic ill);
    exp_t e;
    e.id  = ID_W'(id);
    e.res = res;
    e.ill = ill;
    sb.push_back(e);
  endtask

  // Single-requester transaction: check grant, operand registers in EXEC, and 2-cycle latency.
  task automatic do_op(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic ill);
    set_req(id, op, a, b);
    req_valid = NUM_REQ'(1) << id;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(NUM_REQ'(1) << id));
    push(id, res, ill);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("exec_alu_opcode", 64'(alu_opcode), 64'(op));
    chk("exec_alu_a",      64'(alu_a),      64'(a));
    chk("exec_alu_b",      64'(alu_b),      64'(b));
    chk("exec_rsp_valid",  64'(rsp_valid),  64'(0));
    @(negedge clk);
    chk("latency_rsp_valid", 64'(rsp_valid), 64'(1));
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(sb.size()), 64'(0));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  localparam logic [31:0] FAIR_RES [NUM_REQ] = '{32'd123, 32'd42, 32'h00F0_000F, 32'h1200_0034};

  task automatic load_fair();
    set_req(0, OP_ADD, 32'd100, 32'd23);
    set_req(1, OP_SUB, 32'd50, 32'd8);
    set_req(2, OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    set_req(3, OP_OR,  32'h1200_0000, 32'h0000_0034);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int grants;
    int cyc;
    int last_cyc;
    int idx;

    for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'd0, 32'd0, 32'd0);
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset_req_ready",   64'(req_ready),   64'(0));
    chk("reset_rsp_valid",   64'(rsp_valid),   64'(0));
    chk("reset_rsp_id",      64'(rsp_id),      64'(0));
    chk("reset_rsp_result",  64'(rsp_result),  64'(0));
    chk("reset_rsp_illegal", 64'(rsp_illegal), 64'(0));
    chk("reset_alu_opcode",  64'(alu_opcode),  64'(0));
    chk("reset_alu_a",       64'(alu_a),       64'(0));
    chk("reset_alu_b",       64'(alu_b),       64'(0));
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();

    do_op(2, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);

    do_op(1, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    do_op(0, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0);
    do_op(3, OP_AND, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 1'b0);
    do_op(2, OP_OR,  32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0);
    do_op(3, OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);

    do_op(1, 4'b1001, 32'd3, 32'd4, 32'd0, 1'b1);
    do_op(0, 4'b0101, 32'd9, 32'd9, 32'd0, 1'b1);
    do_op(3, OP_XOR, 32'd5, 32'd3, 32'd6, 1'b0);

    // Reset while the request is in EXEC: nothing may be reported and the pointer returns to NUM_REQ-1.
    set_req(2, OP_ADD, 32'd1, 32'd1);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rstexec_grant", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = 4'b1111;
    rst = 1'b1;
    @(negedge clk);
    chk("rstexec_req_ready_in_rst", 64'(req_ready), 64'(0));
    tick();
    rst = 1'b0;
    req_valid = '0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rstexec_no_rsp", 64'(rsp_valid), 64'(0));
    end
    tick();
    load_fair();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("rstexec_ptr_grant", 64'(req_ready), 64'(4'b0010));
    push(1, FAIR_RES[1], 1'b0);
    tick();
    req_valid = '0;
    drain();

    // Fairness from a fresh pointer: expect 0,1,2,3,0,1 every 3 cycles.
    do_reset();
    load_fair();
    req_valid = '1;
    grants = 0;
    cyc = 0;
    last_cyc = 0;
    while (grants < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        idx = -1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
        chk("fair_order", 64'(idx), 64'(grants % NUM_REQ));
        if (grants > 0) chk("fair_spacing", 64'(cyc - last_cyc), 64'(3));
        last_cyc = cyc;
        if (idx >= 0) push(idx, FAIR_RES[idx], 1'b0);
        grants++;
      end
      tick();
    end
    chk("fair_grant_count", 64'(grants), 64'(6));
    req_valid = '0;
    drain();

    // Back-pressure: pointer sits at 1, so requester 2 wins, then 3 right after release.
    rsp_ready = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("bp_grant", 64'(req_ready), 64'(4'b0100));
    push(2, FAIR_RES[2], 1'b0);
    tick();
    @(negedge clk);
    chk("bp_exec_req_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    for (int n = 0; n < 5; n++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_valid",     64'(rsp_valid),  64'(1));
      chk("bp_hold_id",        64'(rsp_id),     64'(2));
      chk("bp_hold_result",    64'(rsp_result), 64'(FAIR_RES[2]));
      chk("bp_hold_req_ready", 64'(req_ready),  64'(0));
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req_ready", 64'(req_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("bp_next_grant", 64'(req_ready), 64'(4'b1000));
    push(3, FAIR_RES[3], 1'b0);
    tick();
    req_valid = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
